// File: rtl/pan_div_request.sv
`timescale 1ns/1ps
// Pan-angle divider front end: forms |dx|,|dy| and signs, orders them and issues one divide.
// Optional small-move suppression is compiled in with `define PAN_DIV_DEADBAND_EN.
module pan_div_request #(
  parameter int COORD_W        = 10,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DEADBAND       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coord_valid,
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic [COORD_W-1:0] fix_x,
  input  logic [COORD_W-1:0] fix_y,
  input  logic               pan_div_rfd,
  input  logic               pan_div_ready,
  output logic [COORD_W-1:0] pan_dividend,
  output logic [COORD_W-1:0] pan_divisor,
  output logic               pan_div_nd,
  output logic               x_greater_than_y_del,
  output logic               dx_neg,
  output logic               dy_neg,
  output logic               busy,
  output logic               zero_vector,
  output logic               div_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [COORD_W+1:0] DB_S = (COORD_W+2)'(DEADBAND);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  state_t                  ret_state_s;
  logic [COORD_W-1:0]      cap_obj_x_r;
  logic [COORD_W-1:0]      cap_obj_y_r;
  logic [COORD_W-1:0]      cap_fix_x_r;
  logic [COORD_W-1:0]      cap_fix_y_r;
  logic [COORD_W-1:0]      pend_obj_x_r;
  logic [COORD_W-1:0]      pend_obj_y_r;
  logic [COORD_W-1:0]      pend_fix_x_r;
  logic [COORD_W-1:0]      pend_fix_y_r;
  logic                    pend_r;
  logic [CNT_W-1:0]        cnt_r;
  logic signed [COORD_W:0] dx_s;
  logic signed [COORD_W:0] dy_s;
  logic [COORD_W-1:0]      mag_x_s;
  logic [COORD_W-1:0]      mag_y_s;
  logic                    zero_s;
  logic                    x_ge_s;
  logic                    skip_s;
  logic                    load_s;
  logic                    fire_s;
  logic                    ret_load_s;

  // The negation of the most negative value cannot occur: |d| never exceeds 2^COORD_W - 1.
  function automatic logic [COORD_W-1:0] magnitude(input logic signed [COORD_W:0] d);
    logic signed [COORD_W:0] n;
    n = -d;
    if (d[COORD_W]) begin
      return n[COORD_W-1:0];
    end else begin
      return d[COORD_W-1:0];
    end
  endfunction

  // Signed axis deltas and ordered magnitudes of the captured request
  always_comb begin
    dx_s    = $signed({1'b0, cap_obj_x_r}) - $signed({1'b0, cap_fix_x_r});
    dy_s    = $signed({1'b0, cap_obj_y_r}) - $signed({1'b0, cap_fix_y_r});
    mag_x_s = magnitude(dx_s);
    mag_y_s = magnitude(dy_s);
    zero_s  = (mag_x_s == {COORD_W{1'b0}}) && (mag_y_s == {COORD_W{1'b0}});
    x_ge_s  = (mag_x_s >= mag_y_s);
  end

`ifdef PAN_DIV_DEADBAND_EN
  logic signed [COORD_W:0]   last_dx_r;
  logic signed [COORD_W:0]   last_dy_r;
  logic                      last_vld_r;
  logic signed [COORD_W+1:0] ddx_s;
  logic signed [COORD_W+1:0] ddy_s;

  // Suppress a divide when both axes moved less than the deadband since the last issued one
  always_comb begin
    ddx_s  = $signed({dx_s[COORD_W], dx_s}) - $signed({last_dx_r[COORD_W], last_dx_r});
    ddy_s  = $signed({dy_s[COORD_W], dy_s}) - $signed({last_dy_r[COORD_W], last_dy_r});
    skip_s = last_vld_r && !zero_s &&
             (ddx_s < DB_S) && (ddx_s > -DB_S) &&
             (ddy_s < DB_S) && (ddy_s > -DB_S);
  end

  // Reference deltas follow issued requests only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_dx_r  <= {(COORD_W+1){1'b0}};
      last_dy_r  <= {(COORD_W+1){1'b0}};
      last_vld_r <= 1'b0;
    end else if (fire_s) begin
      last_dx_r  <= dx_s;
      last_dy_r  <= dy_s;
      last_vld_r <= 1'b1;
    end
  end
`else
  logic unused_deadband_s;
  assign unused_deadband_s = ^DB_S;
  assign skip_s            = 1'b0;
`endif

  // Next state; nd and timeout are decoded from the state so they land on the cycle itself
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    fire_s      = 1'b0;
    div_timeout = 1'b0;
    ret_load_s  = coord_valid || pend_r;
    ret_state_s = ret_load_s ? CALC : IDLE;
    case (state_r)
      IDLE: begin
        if (coord_valid) begin
          state_s = CALC;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (zero_s || skip_s) begin
          state_s = ret_state_s;
          load_s  = ret_load_s;
        end else begin
          state_s = ISSUE;
        end
      end
      ISSUE: begin
        if (pan_div_rfd) begin
          state_s = WAIT;
          fire_s  = 1'b1;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        if (pan_div_ready) begin
          state_s = ret_state_s;
          load_s  = ret_load_s;
        end else if (cnt_r == CNT_LAST) begin
          div_timeout = 1'b1;
          state_s     = ret_state_s;
          load_s      = ret_load_s;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign pan_div_nd = fire_s;

  // State register and busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
    end
  end

  // Request capture; a strobe arriving while busy lands in the single pending slot (newest wins)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_obj_x_r  <= {COORD_W{1'b0}};
      cap_obj_y_r  <= {COORD_W{1'b0}};
      cap_fix_x_r  <= {COORD_W{1'b0}};
      cap_fix_y_r  <= {COORD_W{1'b0}};
      pend_obj_x_r <= {COORD_W{1'b0}};
      pend_obj_y_r <= {COORD_W{1'b0}};
      pend_fix_x_r <= {COORD_W{1'b0}};
      pend_fix_y_r <= {COORD_W{1'b0}};
      pend_r       <= 1'b0;
    end else if (load_s) begin
      if (coord_valid) begin
        cap_obj_x_r <= obj_x;
        cap_obj_y_r <= obj_y;
        cap_fix_x_r <= fix_x;
        cap_fix_y_r <= fix_y;
      end else begin
        cap_obj_x_r <= pend_obj_x_r;
        cap_obj_y_r <= pend_obj_y_r;
        cap_fix_x_r <= pend_fix_x_r;
        cap_fix_y_r <= pend_fix_y_r;
      end
      pend_r <= 1'b0;
    end else if (coord_valid) begin
      pend_obj_x_r <= obj_x;
      pend_obj_y_r <= obj_y;
      pend_fix_x_r <= fix_x;
      pend_fix_y_r <= fix_y;
      pend_r       <= 1'b1;
    end
  end

  // Cycles spent waiting for the divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (fire_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Divider operands and quadrant flags change only when leaving CALC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pan_dividend         <= {COORD_W{1'b0}};
      pan_divisor          <= {COORD_W{1'b0}};
      x_greater_than_y_del <= 1'b1;
      dx_neg               <= 1'b0;
      dy_neg               <= 1'b0;
      zero_vector          <= 1'b0;
    end else begin
      zero_vector <= 1'b0;
      if ((state_r == CALC) && !skip_s) begin
        dx_neg               <= dx_s[COORD_W];
        dy_neg               <= dy_s[COORD_W];
        x_greater_than_y_del <= x_ge_s;
        if (zero_s) begin
          zero_vector <= 1'b1;
        end else begin
          pan_dividend <= x_ge_s ? mag_y_s : mag_x_s;
          pan_divisor  <= x_ge_s ? mag_x_s : mag_y_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_pan_div_request.sv
`timescale 1ns/1ps
// Self-checking bench for pan_div_request: directed scenarios plus randomized requests
// checked against an arithmetic reference model.
module tb_pan_div_request;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coord_valid = 1'b0;
  logic [9:0] obj_x = 10'd0, obj_y = 10'd0, fix_x = 10'd0, fix_y = 10'd0;
  logic       pan_div_rfd = 1'b0;
  logic       pan_div_ready = 1'b0;
  logic [9:0] pan_dividend, pan_divisor;
  logic       pan_div_nd, x_greater_than_y_del, dx_neg, dy_neg, busy, zero_vector, div_timeout;

  int total = 0;
  int bad = 0;
  int exp_dvd = 0, exp_dvs = 0, exp_xg = 1, exp_dxn = 0, exp_dyn = 0;
  bit lv = 1'b0;
  int ldx = 0, ldy = 0;

  pan_div_request dut (
    .clk(clk), .reset(reset), .coord_valid(coord_valid),
    .obj_x(obj_x), .obj_y(obj_y), .fix_x(fix_x), .fix_y(fix_y),
    .pan_div_rfd(pan_div_rfd), .pan_div_ready(pan_div_ready),
    .pan_dividend(pan_dividend), .pan_divisor(pan_divisor), .pan_div_nd(pan_div_nd),
    .x_greater_than_y_del(x_greater_than_y_del), .dx_neg(dx_neg), .dy_neg(dy_neg),
    .busy(busy), .zero_vector(zero_vector), .div_timeout(div_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_dividend"}, pan_dividend, exp_dvd);
    chk({tag, "_divisor"}, pan_divisor, exp_dvs);
    chk({tag, "_xgreater"}, x_greater_than_y_del, exp_xg);
    chk({tag, "_dxneg"}, dx_neg, exp_dxn);
    chk({tag, "_dyneg"}, dy_neg, exp_dyn);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: plain integer geometry, ties go to the x axis
  function automatic void model(input int ox, oy, fx, fy,
                                output int dx, dy, dvd, dvs, output bit xg, zero);
    int ax, ay;
    dx = ox - fx;
    dy = oy - fy;
    ax = iabs(dx);
    ay = iabs(dy);
    xg = (ax >= ay);
    dvd = xg ? ay : ax;
    dvs = xg ? ax : ay;
    zero = (ax == 0) && (ay == 0);
  endfunction

  task automatic set_reset_expect();
    exp_dvd = 0; exp_dvs = 0; exp_xg = 1; exp_dxn = 0; exp_dyn = 0;
    lv = 1'b0;
  endtask

  // Drive one strobe from IDLE; returns in the CALC cycle
  task automatic launch(input int ox, oy, fx, fy);
    cyc();
    coord_valid = 1'b1;
    obj_x = 10'(ox); obj_y = 10'(oy); fix_x = 10'(fx); fix_y = 10'(fy);
    #1;
    chk("idle_busy", busy, 0);
    cyc();
    coord_valid = 1'b0;
    #1;
    chk("calc_busy", busy, 1);
    chk("calc_nd", pan_div_nd, 0);
  endtask

  // From the CALC cycle: zero-vector, skipped, or issued (returns in the nd cycle)
  task automatic resolve(input int ox, oy, fx, fy, input int rfd_wait, output bit issued);
    int dx, dy, dvd, dvs;
    bit xg, zero, skip;
    model(ox, oy, fx, fy, dx, dy, dvd, dvs, xg, zero);
`ifdef PAN_DIV_DEADBAND_EN
    skip = lv && !zero && (iabs(dx - ldx) < 2) && (iabs(dy - ldy) < 2);
`else
    skip = 1'b0;
`endif
    pan_div_rfd = (rfd_wait == 0);
    issued = 1'b0;
    if (zero) begin
      cyc(); #1;
      chk("zv_pulse", zero_vector, 1);
      chk("zv_busy", busy, 0);
      chk("zv_nd", pan_div_nd, 0);
      exp_xg = 1; exp_dxn = 0; exp_dyn = 0;
      chk_outs("zv");
      cyc(); #1;
      chk("zv_single", zero_vector, 0);
      chk("zv_nd2", pan_div_nd, 0);
    end else if (skip) begin
      cyc(); #1;
      chk("db_busy", busy, 0);
      chk("db_nd", pan_div_nd, 0);
      chk("db_zv", zero_vector, 0);
      chk_outs("db");
    end else begin
      exp_dvd = dvd; exp_dvs = dvs; exp_xg = xg;
      exp_dxn = (dx < 0); exp_dyn = (dy < 0);
      for (int w = 0; w < rfd_wait; w++) begin
        cyc();
        pan_div_ready = 1'($urandom_range(1));
        #1;
        chk("rfd_hold_nd", pan_div_nd, 0);
        chk("rfd_hold_busy", busy, 1);
        chk_outs("rfd_hold");
      end
      cyc();
      pan_div_rfd = 1'b1;
      pan_div_ready = 1'b0;
      #1;
      chk("issue_nd", pan_div_nd, 1);
      chk_outs("issue");
      lv = 1'b1; ldx = dx; ldy = dy;
      issued = 1'b1;
    end
  endtask

  // From the nd cycle: ready arrives ready_wait cycles later (1..63)
  task automatic finish(input int ready_wait);
    for (int k = 1; k < ready_wait; k++) begin
      cyc(); #1;
      chk("wait_nd", pan_div_nd, 0);
      chk("wait_busy", busy, 1);
      chk("wait_to", div_timeout, 0);
      chk_outs("wait");
    end
    cyc();
    pan_div_ready = 1'b1;
    #1;
    chk("ready_busy", busy, 1);
    chk("ready_to", div_timeout, 0);
    chk_outs("ready");
    cyc();
    pan_div_ready = 1'b0;
    #1;
    chk("done_busy", busy, 0);
    chk("done_nd", pan_div_nd, 0);
    chk_outs("done");
  endtask

  initial begin
    bit iss;
    int ox, oy, fx, fy;

    // Reset state
    repeat (3) cyc();
    #1;
    chk("rst_nd", pan_div_nd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zv", zero_vector, 0);
    chk("rst_to", div_timeout, 0);
    chk_outs("rst");
    cyc();
    reset = 1'b1;

    // x-major request, ready after 20 cycles
    launch(612, 334, 512, 384);
    resolve(612, 334, 512, 384, 0, iss);
    chk("t1_dividend_const", pan_dividend, 50);
    chk("t1_divisor_const", pan_divisor, 100);
    chk("t1_dyneg_const", dy_neg, 1);
    finish(20);

    // y-major, then a tie
    launch(500, 584, 512, 384);
    resolve(500, 584, 512, 384, 0, iss);
    chk("t2_dividend_const", pan_dividend, 12);
    chk("t2_xgreater_const", x_greater_than_y_del, 0);
    finish(4);
    launch(562, 434, 512, 384);
    resolve(562, 434, 512, 384, 0, iss);
    chk("t3_tie_divisor_const", pan_divisor, 50);
    finish(2);

    // Zero vector keeps the previous operands
    launch(300, 300, 300, 300);
    resolve(300, 300, 300, 300, 0, iss);

    // Extreme corner
    launch(1023, 0, 0, 1023);
    resolve(1023, 0, 0, 1023, 0, iss);
    finish(3);

    // rfd held low 10 cycles, two strobes while waiting: only the newer one is issued
    launch(100, 900, 512, 384);
    resolve(100, 900, 512, 384, 10, iss);
    cyc(); coord_valid = 1'b1;
    obj_x = 10'd20; obj_y = 10'd30; fix_x = 10'd512; fix_y = 10'd384;
    #1; chk("pend_a_busy", busy, 1);
    cyc(); obj_x = 10'd1000; obj_y = 10'd10;
    #1; chk("pend_b_busy", busy, 1);
    cyc(); coord_valid = 1'b0;
    #1; chk("pend_nd", pan_div_nd, 0);
    cyc(); pan_div_ready = 1'b1;
    #1; chk("pend_ready_to", div_timeout, 0);
    cyc(); pan_div_ready = 1'b0;
    #1;
    chk("pend_calc_busy", busy, 1);
    chk("pend_calc_nd", pan_div_nd, 0);
    resolve(1000, 10, 512, 384, 0, iss);
    finish(5);
    cyc(); #1;
    chk("pend_drained", busy, 0);

    // Timeout exactly 64 cycles after nd
    launch(700, 200, 512, 384);
    resolve(700, 200, 512, 384, 0, iss);
    for (int k = 1; k < 64; k++) begin
      cyc(); #1;
      chk("to_early", div_timeout, 0);
      chk("to_busy", busy, 1);
    end
    cyc(); #1;
    chk("to_pulse", div_timeout, 1);
    cyc(); #1;
    chk("to_single", div_timeout, 0);
    chk("to_idle", busy, 0);

    // Ready on the timeout cycle wins
    launch(400, 100, 512, 384);
    resolve(400, 100, 512, 384, 0, iss);
    for (int k = 1; k < 64; k++) begin
      cyc(); #1;
      chk("race_early", div_timeout, 0);
    end
    cyc(); pan_div_ready = 1'b1;
    #1;
    chk("race_to", div_timeout, 0);
    cyc(); pan_div_ready = 1'b0;
    #1;
    chk("race_idle", busy, 0);
    chk("race_to2", div_timeout, 0);

    // Asynchronous reset mid-wait discards the pending strobe
    launch(10, 1000, 512, 384);
    resolve(10, 1000, 512, 384, 0, iss);
    cyc(); coord_valid = 1'b1;
    obj_x = 10'd900; obj_y = 10'd900;
    cyc(); coord_valid = 1'b0;
    #4;
    reset = 1'b0;
    #1;
    set_reset_expect();
    chk("arst_nd", pan_div_nd, 0);
    chk("arst_busy", busy, 0);
    chk("arst_to", div_timeout, 0);
    chk("arst_zv", zero_vector, 0);
    chk_outs("arst");
    cyc(); reset = 1'b1;
    repeat (3) begin
      cyc(); #1;
      chk("arst_no_pending", busy, 0);
    end

`ifdef PAN_DIV_DEADBAND_EN
    // First request after reset always issues; 1 LSB move is suppressed, 2 LSB is not
    launch(612, 334, 512, 384);
    resolve(612, 334, 512, 384, 0, iss);
    chk("db_first_nd", pan_div_nd, 1);
    finish(3);
    launch(613, 334, 512, 384);
    resolve(613, 334, 512, 384, 0, iss);
    chk("db_1lsb_nd", pan_div_nd, 0);
    launch(614, 334, 512, 384);
    resolve(614, 334, 512, 384, 0, iss);
    chk("db_2lsb_nd", pan_div_nd, 1);
    finish(3);
`endif

    // Randomized requests
    for (int i = 0; i < 30; i++) begin
      fx = int'($urandom_range(1023));
      fy = int'($urandom_range(1023));
      ox = int'($urandom_range(1023));
      oy = int'($urandom_range(1023));
      if ($urandom_range(5) == 0) begin
        ox = fx;
        oy = fy;
      end
      launch(ox, oy, fx, fy);
      resolve(ox, oy, fx, fy, int'($urandom_range(3)), iss);
      if (iss) begin
        finish(int'($urandom_range(12, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pan_div_request.md
Name: pan_div_request

Overview:
- Front end of the pan-angle path: takes a tracked object position and the fixture floor position, forms |dx| and |dy| and their signs, and orders the two magnitudes.
- Issues a single fractional divide request (smaller / larger magnitude) to the pan divider.
- Holds x_greater_than_y_del and the quadrant signs stable until the divider answers with pan_div_ready, so the downstream formatter and arctan stage see aligned inputs.
- Initiator side of the divider handshake: one request outstanding at most.

Parameters:
- COORD_W, 10, width of unsigned position coordinates.
- TIMEOUT_CYCLES, 64, cycles to wait for pan_div_ready before abandoning a request.
- DEADBAND, 2, minimum per-axis change (LSBs) that triggers a new request; used only with DEADBAND_EN.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- coord_valid  in  1  one-cycle strobe: obj_x/obj_y/fix_x/fix_y are valid.
- obj_x  in  COORD_W  tracked object x.
- obj_y  in  COORD_W  tracked object y.
- fix_x  in  COORD_W  fixture x.
- fix_y  in  COORD_W  fixture y.
- pan_div_rfd  in  1  divider ready-for-data.
- pan_div_ready  in  1  divider result-valid strobe.
- pan_dividend  out  COORD_W  min(|dx|,|dy|).
- pan_divisor  out  COORD_W  max(|dx|,|dy|).
- pan_div_nd  out  1  one-cycle new-data strobe to the divider.
- x_greater_than_y_del  out  1  1 when |dx| >= |dy| for the outstanding request.
- dx_neg  out  1  obj_x < fix_x.
- dy_neg  out  1  obj_y < fix_y.
- busy  out  1  request in flight (states CALC, ISSUE, WAIT).
- zero_vector  out  1  one-cycle pulse: dx = dy = 0, no divide issued.
- div_timeout  out  1  one-cycle pulse: divider did not answer in time.

Behaviour:
- Reset (reset = 0, asynchronous): all outputs 0; x_greater_than_y_del = 1; state IDLE; pending flag clear; timeout counter 0.
- Arithmetic:
  - dx = obj_x - fix_x, formed as COORD_W+1-bit signed; |dx| is COORD_W bits unsigned (maximum 1023). dy likewise.
  - Tie |dx| = |dy| goes to x (x_greater_than_y_del = 1; dividend = divisor).
- FSM states: IDLE, CALC, ISSUE, WAIT.
  - IDLE: on coord_valid, capture inputs -> CALC.
  - CALC (1 cycle): register the magnitudes, dx_neg, dy_neg, x_greater_than_y_del, pan_dividend and pan_divisor.
    - If both magnitudes are 0: pulse zero_vector, hold the previous dividend/divisor, -> IDLE.
    - Otherwise -> ISSUE.
  - ISSUE: while pan_div_rfd = 0, hold. When pan_div_rfd = 1, drive pan_div_nd = 1 for exactly one cycle and clear the timeout counter -> WAIT.
  - WAIT: count cycles.
    - pan_div_ready = 1 -> IDLE.
    - Count reaches TIMEOUT_CYCLES without ready -> pulse div_timeout -> IDLE.
    - If ready and timeout occur in the same cycle, ready wins: no timeout pulse.
- Latency: coord_valid at cycle N -> pan_div_nd at cycle N+2 when rfd is already high.
- Stability: pan_dividend, pan_divisor, x_greater_than_y_del, dx_neg and dy_neg change only in CALC. They are stable from nd through the ready cycle inclusive.
- coord_valid while busy:
  - Latch into a single pending slot; a newer strobe overwrites it.
  - On return to IDLE with pending set, go straight to CALC using the pending values and clear pending.
  - coord_valid arriving in the same cycle as the IDLE return is treated as pending (newest wins).
- pan_div_ready in IDLE, CALC or ISSUE is ignored (stale result).
- Reset mid-request: immediate return to IDLE; pending discarded; pan_div_nd forced low.

Optional Feature:
- Macro: PAN_DIV_DEADBAND_EN.
- Defined:
  - In CALC, if |dx - last_dx| < DEADBAND and |dy - last_dy| < DEADBAND (signed deltas of the last issued request), skip the divide and return to IDLE, with no nd and no zero_vector.
  - last_dx/last_dy update only when nd is issued.
  - After reset the first request is always issued.
- Undefined: every non-zero vector issues a divide; no last_* registers exist.

Test Plan:
- Request and ordering: reset, fix=(512,384), obj=(612,334), rfd=1 -> nd at cycle +2 with dividend=50, divisor=100, x_greater_than_y_del=1, dx_neg=0, dy_neg=1; ready after 20 cycles -> busy falls; outputs stable throughout.
- y-major with tie: obj=(500,584) -> dividend=12, divisor=200, x_greater=0, dx_neg=1. Then obj=(562,434) -> dividend=divisor=50, x_greater=1.
- Zero vector: obj=fix=(300,300) -> zero_vector pulse, no nd, busy low after 2 cycles.
- rfd and pending: hold rfd=0 for 10 cycles -> nd is delayed until rfd rises. During WAIT send two coord_valid strobes -> only the second is issued after ready.
- Timeout and race: never assert ready -> div_timeout exactly TIMEOUT_CYCLES=64 cycles after nd. Repeat with ready on cycle 64 -> no timeout pulse.
- Async reset: pull reset low mid-WAIT, asynchronous to clk -> all outputs reset immediately, x_greater=1. With PAN_DIV_DEADBAND_EN defined, obj moves by 1 LSB -> no nd; a 2 LSB move -> nd.
